// File: rtl/uart_tx.sv
// 8N1 serial transmitter with its own 16x-oversampled baud tick generator.
// The frame is start bit, DBIT data bits LSB first, then SB_TICK ticks of stop level.
module uart_tx #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int BAUD_DIV = 163
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic [DBIT-1:0] i_data,
  output logic            o_tx,
  output logic            o_tx_done_tick,
  output logic            o_busy,
  output logic [1:0]      dbg_state
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [5:0]    BIT_LAST  = 6'd15;
  localparam logic [5:0]    STOP_LAST = 6'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [BW-1:0]   baud;
  logic [5:0]      s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] shreg;
  logic [DBIT-1:0] shreg_next;
  logic            tick;

  assign tick           = (state != IDLE) && (baud == BAUD_LAST);
  assign shreg_next     = shreg >> 1;
  // Decoded, not registered, so the controller can drop tx_start before IDLE.
  assign o_tx_done_tick = (state == STOP) && tick && (s == STOP_LAST);
  assign o_busy         = (state != IDLE);
  assign dbg_state      = state;

  // Baud counter holds at zero in IDLE so each frame starts phase-aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud <= '0;
    end else if (state == IDLE || baud == BAUD_LAST) begin
      baud <= '0;
    end else begin
      baud <= baud + BW'(1);
    end
  end

  // o_tx is loaded with the level of the state being entered, so the line
  // always matches the state the FSM is currently in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      shreg <= '0;
      o_tx  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (tx_start) begin
            state <= START;
            shreg <= i_data;
            s     <= '0;
            o_tx  <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            if (s == BIT_LAST) begin
              state <= DATA;
              s     <= '0;
              n     <= '0;
              o_tx  <= shreg[0];
            end else begin
              s <= s + 6'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == BIT_LAST) begin
              s     <= '0;
              shreg <= shreg_next;
              if (n == N_LAST) begin
                state <= STOP;
                o_tx  <= 1'b1;
              end else begin
                n    <= n + NW'(1);
                o_tx <= shreg_next[0];
              end
            end else begin
              s <= s + 6'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s == STOP_LAST) begin
              state <= IDLE;
              o_tx  <= 1'b1;
            end else begin
              s <= s + 6'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          o_tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART ALU path. It takes the ALU result byte from the UART/ALU control interface and sends it on the serial line as an 8N1 frame: start bit, DBIT data bits LSB first, then the stop period. The block has its own 16x-oversampled baud tick generator. It reports frame completion with a one-cycle `o_tx_done_tick`, which the control interface uses to release `tx_start` and return to waiting for the next operand.

## Interface
- `DBIT`, 8: data bits per frame.
- `SB_TICK`, 16: baud ticks in the stop period. 16 gives 1 stop bit, 24 gives 1.5, 32 gives 2.
- `BAUD_DIV`, 163: clock cycles per baud tick, with 16 ticks per bit. The default is 50 MHz / (19200·16), rounded. Minimum is 1.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_start`  in  1  level request to send `i_data`; sampled only in IDLE.
- `i_data`  in  DBIT  byte to transmit; captured on the accept cycle.
- `o_tx`  out  1  serial line, registered, idle-high.
- `o_tx_done_tick`  out  1  one-cycle pulse in the last cycle of the stop period.
- `o_busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Reset values:** state IDLE, `o_tx`=1, `o_tx_done_tick`=0, `o_busy`=0. The baud counter, tick counter `s`, bit counter `n` and shift register are all cleared.
- **Reset mid-frame:** reset acts immediately. `o_tx` returns to 1 without waiting for a clock, the frame is abandoned, and no done tick is produced.
- **Baud counter:** counts 0..BAUD_DIV-1.
  - It runs only outside IDLE and is cleared on the accept cycle, so every frame starts phase-aligned.
  - `tick` is high when the counter equals BAUD_DIV-1.
- **IDLE:** line is 1. If `tx_start`=1, capture `i_data` into the shift register, clear `s`, and go to START. Otherwise stay in IDLE.
- **START:** line is 0.
  - On a tick with `s`=15: clear `s` and `n`, go to DATA.
  - On any other tick: increment `s`.
- **DATA:** line equals shift register bit 0.
  - On a tick with `s`=15: clear `s` and shift the register right. If `n`=DBIT-1 go to STOP, otherwise increment `n`.
  - On any other tick: increment `s`.
- **STOP:** line is 1.
  - On a tick with `s`=SB_TICK-1: assert `o_tx_done_tick` in that same cycle and go to IDLE.
  - On any other tick: increment `s`.
- **Done tick and `tx_start`:** `o_tx_done_tick` is decoded from the current state and is not delayed by a register. This lets the control interface drop `tx_start` before the FSM re-enters IDLE. If `tx_start` is still high in the first IDLE cycle, a new frame starts; `tx_start` is level-sensitive with no edge detection.
- **Data capture:** `i_data` is only used on the accept cycle. Changes to it during a frame have no effect.
- **`o_tx` register:** its next value is computed from the next state, so the line level always matches the state the FSM is currently in.
- **Counter widths:** `s` is 6 bits, `n` is clog2(DBIT) bits, and the baud counter is max(1, clog2(BAUD_DIV)) bits.

## Timing
Let T be the accept cycle (IDLE with `tx_start`=1) and D = BAUD_DIV.
- Start bit: `o_tx`=0 for cycles T+1 .. T+16D.
- Data bit k: cycles T+1+(k+1)·16D .. T+(k+2)·16D.
- Stop period: `o_tx`=1 from T+1+(DBIT+1)·16D for SB_TICK·D cycles.
- Done tick: `o_tx_done_tick` is high in exactly one cycle, TD = T+(DBIT+1)·16D+SB_TICK·D.
- Return to IDLE: the FSM is in IDLE at TD+1, and `o_busy` goes low at TD+1.
- Earliest next frame: accept at TD+1, start bit from TD+2. The line is therefore high for at least one cycle beyond the stop period.
- `o_busy` rises at T+1.

## Test plan
1. **Reset:** hold `reset`=0 with `tx_start`=1 for 10 cycles. Required: `o_tx`=1, `o_busy`=0 and `o_tx_done_tick`=0 throughout, and no frame starts.
2. **Single frame:** BAUD_DIV=4, `i_data`=8'hA5, pulse `tx_start` for one cycle at T. Sampling `o_tx` at each bit centre T+32+64k for k=0..9 must give 0,1,0,1,0,0,1,0,1,1. `o_tx_done_tick` must be high only at T+640.
3. **Handshake with the control interface:** hold `tx_start` high until the cycle where `o_tx_done_tick`=1, and drop it combinationally in that cycle. Required: exactly one frame, then IDLE with `o_tx`=1 for 1000 cycles.
4. **Back-to-back frames:** hold `tx_start` high, sending 8'h3C then 8'hFF. Required: the second start bit begins at T+642, and two done ticks occur 641 cycles apart.
5. **Data stability:** change `i_data` from 8'h0F to 8'hF0 at T+100. Required: the transmitted bits are 0x0F, LSB first.
6. **Reset mid-frame:** assert `reset`=0 during data bit 3 of 8'h00. Required: `o_tx`=1 without waiting for a clock edge, no done tick, and a fresh 8'h55 frame after release times correctly per scenario 2.
